// File: rtl/pad_map_pkg.sv
// Shared constants, FSM encoding and sizing helper for the pad match-map loader.
package pad_map_pkg;
  localparam int MAP_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_CHECK  = 2'd2,
    S_COMMIT = 2'd3
  } state_e;

  // Word counter / pad index width; never narrower than one bit.
  function automatic int clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pad_map_bank.sv
// Shadow and active map storage: shadow is filled word by word, active loads all maps at once.
module pad_map_bank
  import pad_map_pkg::*;
#(
  parameter int NUM_PADS = 8,
  parameter int IDX_W    = clog2(NUM_PADS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [MAP_W-1:0]                 wr_data,
  input  logic                             commit,
  output logic [NUM_PADS-1:0][MAP_W-1:0]   active_map
);
  logic [NUM_PADS-1:0][MAP_W-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else begin
      for (int k = 0; k < NUM_PADS; k++)
        if (wr_en && wr_idx == IDX_W'(k)) shadow[k] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      active_map <= '0;
    else if (commit) active_map <= shadow;
  end
endmodule

// File: rtl/pad_map_loader.sv
// Framed slow-control writer for the per-pad match maps with atomic commit.
// Optional trailing XOR checksum word: define PAD_MAP_CHECKSUM_EN.
module pad_map_loader
  import pad_map_pkg::*;
#(
  parameter int NUM_PADS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      cfg_sof,
  input  logic [MAP_W-1:0]          cfg_data,
  input  logic                      cfg_abort,
  output logic [NUM_PADS*MAP_W-1:0] pad_matched_map,
  output logic                      map_loaded,
  output logic                      load_busy,
  output logic                      commit_done,
  output logic                      load_err
);
  localparam int              CNT_W = clog2(NUM_PADS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PADS - 1);

  state_e                         state, state_d;
  logic [CNT_W-1:0]               cnt, cnt_d, wr_idx;
  logic                           wr_en, err_d, xfer, commit_now;
  logic [2:1]                     vld_pipe;
  logic [NUM_PADS-1:0][MAP_W-1:0] active_map;
`ifdef PAD_MAP_CHECKSUM_EN
  logic [MAP_W-1:0]               acc, acc_d;
`endif

  assign cfg_ready       = (state != S_COMMIT);
  assign xfer            = cfg_valid & cfg_ready;
  assign load_busy       = (state != S_IDLE);
  assign commit_now      = (state == S_COMMIT);
  assign commit_done     = vld_pipe[2];
  assign pad_matched_map = active_map;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wr_en   = 1'b0;
    wr_idx  = cnt;
    err_d   = 1'b0;
`ifdef PAD_MAP_CHECKSUM_EN
    acc_d   = acc;
`endif
    case (state)
      S_IDLE: if (xfer) begin
        if (cfg_sof) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          cnt_d   = CNT_W'(1);
          state_d = S_LOAD;
`ifdef PAD_MAP_CHECKSUM_EN
          acc_d   = cfg_data;
`endif
        end else begin
          err_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (cfg_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (xfer) begin
          wr_en = 1'b1;
          if (cfg_sof) begin
            // Restart: this word becomes word 0 of the new frame.
            err_d  = 1'b1;
            wr_idx = '0;
            cnt_d  = CNT_W'(1);
`ifdef PAD_MAP_CHECKSUM_EN
            acc_d  = cfg_data;
`endif
          end else begin
`ifdef PAD_MAP_CHECKSUM_EN
            acc_d = acc ^ cfg_data;
`endif
            if (cnt == LAST) begin
              cnt_d   = '0;
`ifdef PAD_MAP_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_COMMIT;
`endif
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        end
      end
`ifdef PAD_MAP_CHECKSUM_EN
      S_CHECK: begin
        if (cfg_abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          // A sof here is not restarted; the sender resends the whole frame.
          if (!cfg_sof && cfg_data == acc) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Commit is staged one cycle so the active-bank load is a plain register copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      load_err   <= 1'b0;
      map_loaded <= 1'b0;
      vld_pipe   <= '0;
`ifdef PAD_MAP_CHECKSUM_EN
      acc        <= '0;
`endif
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      load_err <= err_d;
      vld_pipe <= {vld_pipe[1], commit_now};
      if (vld_pipe[1]) map_loaded <= 1'b1;
`ifdef PAD_MAP_CHECKSUM_EN
      acc      <= acc_d;
`endif
    end
  end

  pad_map_bank #(.NUM_PADS(NUM_PADS), .IDX_W(CNT_W)) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (cfg_data),
    .commit     (vld_pipe[1]),
    .active_map (active_map)
  );
endmodule

// File: tb/tb_pad_map_loader.sv
// Bench for pad_map_loader (NUM_PADS=4): frame table, directed corner cases, random vs frame model.
module tb_pad_map_loader;
  localparam int NP = 4;
`ifdef PAD_MAP_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_sof = 1'b0, cfg_abort = 1'b0;
  logic [15:0] cfg_data = '0;
  logic cfg_ready, map_loaded, load_busy, commit_done, load_err;
  logic [NP*16-1:0] pad_matched_map;

  always #5 clk = ~clk;

  pad_map_loader #(.NUM_PADS(NP)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sof(cfg_sof), .cfg_data(cfg_data), .cfg_abort(cfg_abort),
    .pad_matched_map(pad_matched_map), .map_loaded(map_loaded), .load_busy(load_busy),
    .commit_done(commit_done), .load_err(load_err)
  );

  int n_vec = 0, n_err = 0, err_seen = 0, done_seen = 0;

  always @(negedge clk) if (rst_n) begin
    if (load_err)    err_seen++;
    if (commit_done) done_seen++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: frames are queues of words; a complete frame appears
  // on the active maps two edges after its last word.
  logic [15:0] m_active [NP];
  logic [15:0] m_pend [NP];
  logic [15:0] m_q [$];
  bit m_in, m_blk, m_loaded, m_done;
  int m_cd, m_errs = 0, m_commits = 0;

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) begin m_active[i] = '0; m_pend[i] = '0; end
    m_q.delete();
    m_in = 0; m_blk = 0; m_loaded = 0; m_done = 0; m_cd = 0;
  endfunction

  function automatic logic [15:0] xor_q();
    logic [15:0] x = '0;
    foreach (m_q[i]) x ^= m_q[i];
    return x;
  endfunction

  function automatic logic [63:0] pack_active();
    logic [63:0] r = '0;
    for (int i = 0; i < NP; i++) r[16*i +: 16] = m_active[i];
    return r;
  endfunction

  function automatic void model_step(input bit v, input bit s, input logic [15:0] d, input bit a);
    bit commit = 0;
    m_done = 0;
    if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) begin
        for (int i = 0; i < NP; i++) m_active[i] = m_pend[i];
        m_loaded = 1; m_done = 1; m_commits++;
      end
    end
    if (!m_blk) begin
      if (m_in && a) begin
        m_in = 0; m_q.delete();
      end else if (v) begin
        if (m_in && m_q.size() == NP) begin
          if (s || d != xor_q()) m_errs++;
          else commit = 1;
          m_in = 0;
        end else if (s) begin
          if (m_in) m_errs++;
          m_q.delete(); m_q.push_back(d); m_in = 1;
        end else if (!m_in) begin
          m_errs++;
        end else begin
          m_q.push_back(d);
          if (m_q.size() == NP && !CHK) begin commit = 1; m_in = 0; end
        end
      end
    end
    if (commit) begin
      for (int i = 0; i < NP; i++) m_pend[i] = m_q[i];
      m_q.delete();
      m_cd = 2;
    end
    m_blk = commit;
  endfunction

  task automatic step(input bit v, input bit s, input logic [15:0] d, input bit a);
    logic rdy;
    @(negedge clk);
    cfg_valid = v; cfg_sof = s; cfg_data = d; cfg_abort = a;
    #1 rdy = cfg_ready;
    chk("cfg_ready", rdy, !m_blk);
    @(posedge clk);
    model_step(v, s, d, a);
    #1;
    chk("pad_matched_map", pad_matched_map, pack_active());
    chk("map_loaded", map_loaded, m_loaded);
    chk("commit_done", commit_done, m_done);
    chk("load_busy", load_busy, m_in || m_blk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0);
  endtask

  function automatic logic [15:0] xor4(input logic [3:0][15:0] w);
    return w[0] ^ w[1] ^ w[2] ^ w[3];
  endfunction

  task automatic send_frame(input logic [3:0][15:0] w, input int gap);
    for (int k = 0; k < NP; k++) begin
      step(1, k == 0, w[k], 0);
      for (int g = 0; g < gap; g++) step(0, 0, 16'h0, 0);
    end
    if (CHK) step(1, 0, xor4(w), 0);
  endtask

  typedef struct {
    logic [3:0][15:0] w;
    int               gap;
    logic [63:0]      exp;
  } fvec_t;

  fvec_t tbl [4];

  initial begin
    int e0, d0;
    logic [3:0][15:0] w;
    tbl[0].w = {16'h1000, 16'h0100, 16'h0010, 16'h0001}; tbl[0].gap = 0; tbl[0].exp = 64'h1000_0100_0010_0001;
    tbl[1].w = {16'h1000, 16'h0100, 16'h0010, 16'h0001}; tbl[1].gap = 2; tbl[1].exp = 64'h1000_0100_0010_0001;
    tbl[2].w = {16'h5678, 16'h1234, 16'hBEEF, 16'hDEAD}; tbl[2].gap = 1; tbl[2].exp = 64'h5678_1234_BEEF_DEAD;
    tbl[3].w = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; tbl[3].gap = 0; tbl[3].exp = 64'hFFFF_FFFF_FFFF_FFFF;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset map", pad_matched_map, 64'h0);
    chk("reset map_loaded", map_loaded, 0);
    chk("reset load_busy", load_busy, 0);
    chk("reset commit_done", commit_done, 0);
    chk("reset load_err", load_err, 0);
    chk("reset cfg_ready", cfg_ready, 1);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      e0 = err_seen; d0 = done_seen;
      send_frame(tbl[i].w, tbl[i].gap);
      idle(3);
      chk("tbl map", pad_matched_map, tbl[i].exp);
      chk("tbl map_loaded", map_loaded, 1);
      chk("tbl done count", done_seen - d0, 1);
      chk("tbl err count", err_seen - e0, 0);
    end

    // Stray word outside a frame.
    e0 = err_seen; d0 = done_seen;
    step(1, 0, 16'hFFFF, 0);
    chk("stray busy", load_busy, 0);
    idle(3);
    chk("stray err count", err_seen - e0, 1);
    chk("stray map", pad_matched_map, tbl[3].exp);
    chk("stray done count", done_seen - d0, 0);

    // sof in the middle of a frame restarts it.
    e0 = err_seen;
    w = {16'h000D, 16'h000C, 16'h000B, 16'hAAAA};
    step(1, 1, 16'h1111, 0);
    step(1, 0, 16'h2222, 0);
    send_frame(w, 0);
    idle(3);
    chk("restart err count", err_seen - e0, 1);
    chk("restart map", pad_matched_map, 64'h000D_000C_000B_AAAA);

    // Abort after word 2 leaves the active maps alone.
    send_frame(tbl[0].w, 0);
    idle(3);
    e0 = err_seen; d0 = done_seen;
    step(1, 1, 16'h0001, 0);
    step(1, 0, 16'h0010, 0);
    step(0, 0, 16'h0, 1);
    idle(3);
    chk("abort map", pad_matched_map, tbl[0].exp);
    chk("abort err count", err_seen - e0, 0);
    chk("abort done count", done_seen - d0, 0);
    chk("abort busy", load_busy, 0);

    if (CHK) begin
      e0 = err_seen; d0 = done_seen;
      for (int k = 0; k < NP; k++) step(1, k == 0, 16'(k + 5), 0);
      step(1, 0, 16'h0000, 0);
      idle(3);
      chk("bad checksum err", err_seen - e0, 1);
      chk("bad checksum map", pad_matched_map, tbl[0].exp);
      e0 = err_seen;
      for (int k = 0; k < NP; k++) step(1, k == 0, 16'(k + 5), 0);
      step(1, 1, 16'h1234, 0);
      chk("sof in check busy", load_busy, 0);
      idle(3);
      chk("sof in check err", err_seen - e0, 1);
      chk("sof in check done", done_seen - d0, 0);
    end

    // Reset mid-frame.
    step(1, 1, 16'h7777, 0);
    step(1, 0, 16'h8888, 0);
    @(negedge clk);
    cfg_valid = 0; cfg_sof = 0; cfg_abort = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset map", pad_matched_map, 64'h0);
    chk("midreset map_loaded", map_loaded, 0);
    chk("midreset load_busy", load_busy, 0);
    chk("midreset commit_done", commit_done, 0);
    chk("midreset load_err", load_err, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    send_frame(tbl[2].w, 0);
    idle(3);
    chk("post-reset map", pad_matched_map, tbl[2].exp);
    chk("post-reset map_loaded", map_loaded, 1);

    // Random traffic against the frame model.
    for (int i = 0; i < 1500; i++) begin
      bit v, s, a;
      logic [15:0] d;
      v = ($urandom_range(0, 3) != 0);
      s = m_in ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 29) == 0);
      d = 16'($urandom);
      if (CHK && m_in && m_q.size() == NP && $urandom_range(0, 3) != 0) d = xor_q();
      step(v, s, d, a);
    end
    idle(3);
    chk("total err pulses", err_seen, m_errs);
    chk("total commits", done_seen, m_commits);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
